// File: rtl/frame_phase_scheduler.sv
// Frame tick divider plus an NPH-phase start/done sequencer with dropped-frame tracking.
// Define FRAME_WDT_EN to build the per-phase watchdog; otherwise wdt_fault is tied low.
module frame_phase_scheduler #(
  parameter int unsigned TICK_DIV   = 1666667,
  parameter int unsigned NPH        = 3,
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr_status,
  input  logic [NPH-1:0] phase_done,
  output logic [NPH-1:0] phase_start,
  output logic           frame_tick,
  output logic           busy,
  output logic [2:0]     cur_phase,
  output logic [15:0]    frame_cnt,
  output logic           overrun,
  output logic [7:0]     overrun_cnt,
  output logic           wdt_fault
);

  localparam int unsigned DW = $clog2(TICK_DIV);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t         r_state;
  logic [DW-1:0]  r_div_cnt;
  logic [NPH-1:0] r_phase_start;
  logic           r_busy;
  logic [2:0]     r_cur_phase;
  logic [15:0]    r_frame_cnt;
  logic           r_overrun;
  logic [7:0]     r_overrun_cnt;

  logic           w_tick;
  logic           w_done;
  logic           w_last;
  logic           w_ovr;
  logic           w_wdt_to;
  logic [NPH-1:0] w_next_start;

  assign w_tick = en && (r_div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!en || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // Only the done bit of the currently active phase is honoured.
  always_comb begin
    w_done = 1'b0;
    for (int unsigned i = 0; i < NPH; i++) begin
      if (r_cur_phase == 3'(i) && phase_done[i]) begin
        w_done = 1'b1;
      end
    end
    if (r_state != S_RUN) begin
      w_done = 1'b0;
    end
  end

  assign w_last       = (r_cur_phase == 3'(NPH - 1));
  assign w_next_start = NPH'(1) << (r_cur_phase + 3'd1);
  // A tick landing on the final done is absorbed by a back-to-back restart.
  assign w_ovr        = w_tick && (r_state == S_RUN) && !(w_done && w_last);

`ifdef FRAME_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

  logic [WW-1:0] r_wdt_cnt;
  logic          r_wdt_fault;

  assign w_wdt_to = (r_state == S_RUN) && !w_done && (r_wdt_cnt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt   <= '0;
      r_wdt_fault <= 1'b0;
    end else begin
      if (r_state == S_RUN && !w_done && !w_wdt_to) begin
        r_wdt_cnt <= r_wdt_cnt + WW'(1);
      end else begin
        r_wdt_cnt <= '0;
      end
      if (w_wdt_to) begin
        r_wdt_fault <= 1'b1;
      end else if (clr_status) begin
        r_wdt_fault <= 1'b0;
      end
    end
  end

  assign wdt_fault = r_wdt_fault;
`else
  // Watchdog not built: the timeout term is a constant zero.
  assign w_wdt_to  = 1'b0 & (WDT_CYCLES == 0);
  assign wdt_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase_start <= '0;
      r_busy        <= 1'b0;
      r_cur_phase   <= '0;
      r_frame_cnt   <= '0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_phase_start <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state       <= S_RUN;
            r_busy        <= 1'b1;
            r_cur_phase   <= '0;
            r_phase_start <= NPH'(1);
          end
        end
        S_RUN: begin
          if (w_done) begin
            if (!w_last) begin
              r_cur_phase   <= r_cur_phase + 3'd1;
              r_phase_start <= w_next_start;
            end else begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_cur_phase <= '0;
              if (w_tick) begin
                r_phase_start <= NPH'(1);
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else if (w_wdt_to) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cur_phase <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_ovr) begin
        r_overrun <= 1'b1;
        if (clr_status) begin
          r_overrun_cnt <= 8'd1;
        end else if (r_overrun_cnt != 8'hFF) begin
          r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
      end else if (clr_status) begin
        r_overrun     <= 1'b0;
        r_overrun_cnt <= '0;
      end
    end
  end

  assign frame_tick  = w_tick;
  assign phase_start = r_phase_start;
  assign busy        = r_busy;
  assign cur_phase   = r_cur_phase;
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;

endmodule

// File: doc/frame_phase_scheduler.md
Name: frame_phase_scheduler

Overview:
- Generates the ~60 Hz frame tick from the 100 MHz system clock.
- On each tick, sequences the per-frame game/VGA work as NPH ordered phases (e.g. input sample, state update, render commit) using start/done handshakes.
- Detects and counts frames dropped because the previous sequence had not finished.
- Sits between the system clock domain and the game logic and VGA framebuffer writer, replacing free-running divided clocks with single-cycle enables.

Parameters:
- TICK_DIV, 1666667, clk cycles per frame tick (100 MHz / 60 Hz); legal range 2 and up.
- NPH, 3, number of sequenced phases; legal range 1–8.
- WDT_CYCLES, 65535, per-phase timeout in clk cycles; used only with FRAME_WDT_EN.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  tick generation enable
- clr_status  in  1  single-cycle clear of overrun status
- phase_done  in  NPH  done strobe per phase; bit i is honoured only while phase i is active
- phase_start  out  NPH  one-cycle start pulse per phase
- frame_tick  out  1  one-cycle pulse per frame period
- busy  out  1  high while any phase is active
- cur_phase  out  3  index of the active phase; 0 when idle
- frame_cnt  out  16  count of completed sequences; wraps
- overrun  out  1  sticky flag: a tick was dropped
- overrun_cnt  out  8  dropped-tick count; saturates at 255
- wdt_fault  out  1  sticky flag: a phase timed out

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset values: all outputs 0, divider counter 0, state IDLE.
  - Reset asserted mid-sequence aborts immediately, with no partial frame_cnt update.
- Divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - frame_tick is high in exactly the cycle the counter equals TICK_DIV-1.
  - en low holds the counter at 0 and produces no ticks. An in-flight sequence still runs to completion.
  - en rising: first tick TICK_DIV cycles later.
- States: IDLE, PH(i) for i = 0..NPH-1.
  - IDLE + frame_tick at cycle T: state becomes PH0 at T+1; phase_start[0]=1 at T+1 only; busy=1 from T+1.
  - PH(i) + phase_done[i] at cycle t:
    - i<NPH-1: state becomes PH(i+1) and phase_start[i+1]=1 at t+1.
    - i=NPH-1: state becomes IDLE at t+1; busy=0 and frame_cnt+1 at t+1.
  - phase_done may arrive in the same cycle as its phase_start pulse and is accepted then. Minimum phase length is 1 cycle, so the minimum sequence is NPH cycles.
  - phase_done bits for inactive phases are ignored. Multiple bits may be set; only bit cur_phase matters.
- cur_phase and busy are registered and track state.
- Overrun (frame_tick while busy):
  - The tick is dropped; no restart and no queueing.
  - overrun is set at the next cycle; overrun_cnt increments, saturating at 255.
  - Exception: frame_tick in the same cycle as phase_done[NPH-1] while in PH(NPH-1) is not an overrun. State goes directly to PH0 at t+1, phase_start[0]=1 at t+1, and frame_cnt still increments.
- clr_status: clears overrun, overrun_cnt and wdt_fault at the next cycle.
  - If an overrun event occurs in the same cycle, the event wins: overrun=1, overrun_cnt=1.
- frame_cnt wraps 0xFFFF to 0x0000.

Optional Feature:
- Macro FRAME_WDT_EN.
- Defined:
  - A per-phase cycle counter resets on every phase entry.
  - If PH(i) stays active WDT_CYCLES cycles without phase_done[i], state goes to IDLE the next cycle, wdt_fault is set (sticky), busy=0, frame_cnt is not incremented and no further phase_start is issued.
  - phase_done[i] arriving in the timeout cycle is honoured; no fault.
- Undefined: no watchdog logic is built, wdt_fault is tied to 0, and phases may last indefinitely.

Test Plan:
1. TICK_DIV=10, NPH=3, en=1, phase_done returned 2 cycles after each start -> frame_tick every 10 cycles; phase_start bits 0,1,2 each pulse once per frame, spaced 3 cycles apart; frame_cnt reaches 5 after 5 ticks; overrun=0.
2. TICK_DIV=10, phase 1 held 15 cycles -> one tick dropped: overrun=1, overrun_cnt=1, no phase_start[0] during busy; frame_cnt counts completed sequences only.
3. Final phase_done coincident with frame_tick -> no overrun; phase_start[0] in the next cycle; frame_cnt increments.
4. Force 300 overruns, then assert clr_status -> overrun_cnt saturates at 255; after clear, overrun=0 and overrun_cnt=0. Clear coincident with an overrun event -> overrun_cnt=1.
5. Assert rst_n=0 during PH1, then release -> all outputs 0 and state IDLE; the first tick after release starts PH0; frame_cnt=0.
6. FRAME_WDT_EN defined, WDT_CYCLES=8, phase 0 never done -> wdt_fault=1 after 8 cycles in PH0, busy=0, frame_cnt unchanged; the next tick restarts PH0 normally.
